pipe_maindec: RTL

PIPE_MAINDEC -- requirements
Module: pipe_maindec

---
 rtl/maindec_pkg.sv | 89 ++++++++
 rtl/maindec_comb.sv | 179 +++++++++++++++++
 rtl/pipe_maindec.sv | 77 +++++++
 3 files changed

// File: rtl/maindec_pkg.sv
// Shared types and constants for the pipelined main decoder: the control bundle,
// opcode constants, field encodings and exception bit positions.
package maindec_pkg;

    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

    localparam logic [31:0] INSTR_ECALL  = 32'h0000_0073;
    localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;
    localparam logic [31:0] INSTR_MRET   = 32'h3020_0073;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_BR  = 2'b01;
    localparam logic [1:0] ALU_OP  = 2'b10;
    localparam logic [1:0] ALU_IMM = 2'b11;

    localparam int unsigned EXC_EBREAK  = 0;
    localparam int unsigned EXC_ECALL   = 1;
    localparam int unsigned EXC_ILLEGAL = 2;
    localparam int unsigned EXC_PRIV    = 3;

    typedef enum logic [2:0] {
        BrNone   = 3'b000,
        BrEq     = 3'b001,
        BrGeu    = 3'b010,
        BrNe     = 3'b011,
        BrGe     = 3'b100,
        BrLt     = 3'b101,
        BrLtu    = 3'b110,
        BrAlways = 3'b111
    } branch_e;

    typedef enum logic [1:0] {
        MrNone     = 2'b00,
        MrUnsigned = 2'b01,
        MrSigned   = 2'b11
    } memread_e;

    typedef enum logic [2:0] {
        MwB = 3'b000,
        MwH = 3'b001,
        MwW = 3'b011,
        MwD = 3'b111
    } memwidth_e;

    typedef enum logic [1:0] {
        RsAlu   = 2'b00,
        RsImm   = 2'b01,
        RsPcImm = 2'b10
    } regsel_e;

    typedef struct packed {
        logic       RegWrite;
        logic       MemWrite;
        memread_e   MemRead;
        branch_e    Branch;
        memwidth_e  memWidth;
        regsel_e    regSel;
        logic [1:0] ALUOp;
        logic       ALUSrc;
        logic       csrWriteEnable;
        logic       trapReturn;
        logic       wArith;
        logic       mulDiv;
        logic [3:0] exceptSignal;
    } ctrl_t;

    // Access size comes straight from funct3[1:0] for both loads and stores.
    function automatic memwidth_e width_of(input logic [1:0] sz);
        case (sz)
            2'b00:   return MwB;
            2'b01:   return MwH;
            2'b10:   return MwW;
            default: return MwD;
        endcase
    endfunction

endpackage

// File: rtl/maindec_comb.sv
// Combinational instruction decoder producing one ctrl_t bundle per word.
// Optional M-extension decode is enabled by defining MAINDEC_MEXT_EN.
module maindec_comb
    import maindec_pkg::*;
#(
    parameter int unsigned XLEN = 64
) (
    input  logic [31:0] instr,
    input  logic [1:0]  privMode,
    output ctrl_t       ctrl
);

    localparam logic Is64 = (XLEN == 64);

    logic [6:0] opcode;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [5:0] f6;
    logic       shift_ok_l;
    logic       shift_ok_r;
    logic       ill;
    logic       priv_viol;
    ctrl_t      c;

    assign opcode = instr[6:0];
    assign f3     = instr[14:12];
    assign f7     = instr[31:25];
    assign f6     = instr[31:26];

    // On RV64 shamt is 6 bits, so only instr[31:26] carries the funct field.
    assign shift_ok_l = Is64 ? (f6 == 6'b000000) : (f7 == 7'b0000000);
    assign shift_ok_r = Is64 ? (f6 == 6'b000000 || f6 == 6'b010000)
                             : (f7 == 7'b0000000 || f7 == 7'b0100000);

    always_comb begin
        c         = '0;
        ill       = 1'b0;
        priv_viol = 1'b0;
        case (opcode)
            OPC_LUI: begin
                c.RegWrite = 1'b1;
                c.regSel   = RsImm;
            end
            OPC_AUIPC: begin
                c.RegWrite = 1'b1;
                c.regSel   = RsPcImm;
            end
            OPC_JAL: begin
                c.RegWrite = 1'b1;
                c.Branch   = BrAlways;
            end
            OPC_JALR: begin
                c.RegWrite = 1'b1;
                c.Branch   = BrAlways;
                c.ALUSrc   = 1'b1;
                ill        = (f3 != 3'b000);
            end
            OPC_BRANCH: begin
                c.ALUOp = ALU_BR;
                case (f3)
                    3'b000:  c.Branch = BrEq;
                    3'b001:  c.Branch = BrNe;
                    3'b100:  c.Branch = BrLt;
                    3'b101:  c.Branch = BrGe;
                    3'b110:  c.Branch = BrLtu;
                    3'b111:  c.Branch = BrGeu;
                    default: ill = 1'b1;
                endcase
            end
            OPC_LOAD: begin
                c.RegWrite = 1'b1;
                c.ALUSrc   = 1'b1;
                c.memWidth = width_of(f3[1:0]);
                c.MemRead  = f3[2] ? MrUnsigned : MrSigned;
                ill        = (f3 == 3'b111) || (!Is64 && (f3 == 3'b011 || f3 == 3'b110));
            end
            OPC_STORE: begin
                c.MemWrite = 1'b1;
                c.ALUSrc   = 1'b1;
                c.memWidth = width_of(f3[1:0]);
                ill        = f3[2] || (!Is64 && f3[1:0] == 2'b11);
            end
            OPC_OP_IMM: begin
                c.RegWrite = 1'b1;
                c.ALUSrc   = 1'b1;
                c.ALUOp    = ALU_IMM;
                if (f3 == 3'b001) ill = !shift_ok_l;
                if (f3 == 3'b101) ill = !shift_ok_r;
            end
            OPC_OP_IMM_32: begin
                c.RegWrite = 1'b1;
                c.ALUSrc   = 1'b1;
                c.ALUOp    = ALU_IMM;
                c.wArith   = 1'b1;
                case (f3)
                    3'b000:  ill = 1'b0;
                    3'b001:  ill = (f7 != 7'b0000000);
                    3'b101:  ill = !(f7 == 7'b0000000 || f7 == 7'b0100000);
                    default: ill = 1'b1;
                endcase
                if (!Is64) ill = 1'b1;
            end
            OPC_OP: begin
                c.RegWrite = 1'b1;
                c.ALUOp    = ALU_OP;
                case (f7)
                    7'b0000000: ill = 1'b0;
                    7'b0100000: ill = !(f3 == 3'b000 || f3 == 3'b101);
`ifdef MAINDEC_MEXT_EN
                    7'b0000001: c.mulDiv = 1'b1;
`endif
                    default:    ill = 1'b1;
                endcase
            end
            OPC_OP_32: begin
                c.RegWrite = 1'b1;
                c.ALUOp    = ALU_OP;
                c.wArith   = 1'b1;
                case (f7)
                    7'b0000000: ill = !(f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b101);
                    7'b0100000: ill = !(f3 == 3'b000 || f3 == 3'b101);
`ifdef MAINDEC_MEXT_EN
                    7'b0000001: begin
                        c.mulDiv = 1'b1;
                        ill      = (f3 == 3'b001 || f3 == 3'b010 || f3 == 3'b011);
                    end
`endif
                    default:    ill = 1'b1;
                endcase
                if (!Is64) ill = 1'b1;
            end
            OPC_MISC_MEM: begin
                ill = (f3[2:1] != 2'b00);
            end
            OPC_SYSTEM: begin
                if (f3 == 3'b000) begin
                    case (instr)
                        INSTR_ECALL:  c.exceptSignal[EXC_ECALL]  = 1'b1;
                        INSTR_EBREAK: c.exceptSignal[EXC_EBREAK] = 1'b1;
                        INSTR_MRET:   c.trapReturn = 1'b1;
                        default:      ill = 1'b1;
                    endcase
                end else if (f3 == 3'b100) begin
                    ill = 1'b1;
                end else begin
                    c.RegWrite       = 1'b1;
                    c.csrWriteEnable = 1'b1;
                    // CSR address bits [29:28] encode the lowest privilege allowed.
                    priv_viol        = (privMode < instr[29:28]);
                end
            end
            default: ill = 1'b1;
        endcase

        // Illegal words yield an empty bundle carrying only the illegal flag.
        if (ill) begin
            c                          = '0;
            c.exceptSignal[EXC_ILLEGAL] = 1'b1;
        end else if (priv_viol) begin
            c.exceptSignal[EXC_PRIV] = 1'b1;
        end

        if (c.exceptSignal != 4'b0000) begin
            c.RegWrite       = 1'b0;
            c.MemWrite       = 1'b0;
            c.MemRead        = MrNone;
            c.Branch         = BrNone;
            c.csrWriteEnable = 1'b0;
        end

        if (!Is64) c.wArith = 1'b0;
`ifndef MAINDEC_MEXT_EN
        c.mulDiv = 1'b0;
`endif
    end

    assign ctrl = c;

endmodule

// File: rtl/pipe_maindec.sv
// One-stage pipelined main decoder: valid/ready handshake, RUN/TRAP FSM, output
// register and saturating illegal-instruction counter. M-extension: MAINDEC_MEXT_EN.
module pipe_maindec
    import maindec_pkg::*;
#(
    parameter int unsigned XLEN      = 64,
    parameter int unsigned ILL_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 coprocessorStall,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          instr,
    input  logic [1:0]           privMode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output ctrl_t                ctrl,
    output logic [ILL_CNT_W-1:0] illCount
);

    typedef enum logic [0:0] {
        StRun  = 1'b0,
        StTrap = 1'b1
    } state_e;

    state_e                 state_q;
    logic                   out_valid_q;
    ctrl_t                  ctrl_q;
    logic [ILL_CNT_W-1:0]   ill_cnt_q;
    ctrl_t                  dec_ctrl;
    logic                   accept;
    logic                   drain;
    logic                   dec_trap;
    logic                   dec_count;

    maindec_comb #(
        .XLEN(XLEN)
    ) u_comb (
        .instr    (instr),
        .privMode (privMode),
        .ctrl     (dec_ctrl)
    );

    // The stall only masks visibility; the held bundle stays in ctrl_q.
    assign out_valid = out_valid_q && !coprocessorStall;
    assign in_ready  = (state_q == StRun) && !coprocessorStall && (!out_valid_q || out_ready);
    assign accept    = in_valid && in_ready;
    assign drain     = out_valid && out_ready;
    assign dec_trap  = (dec_ctrl.exceptSignal != 4'b0000) || dec_ctrl.trapReturn;
    assign dec_count = dec_ctrl.exceptSignal[EXC_ILLEGAL] || dec_ctrl.exceptSignal[EXC_PRIV];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StRun;
            out_valid_q <= 1'b0;
            ctrl_q      <= '0;
            ill_cnt_q   <= '0;
        end else if (flush) begin
            // A word accepted in the flush cycle is dropped and not counted.
            state_q     <= StRun;
            out_valid_q <= 1'b0;
        end else if (accept) begin
            ctrl_q      <= dec_ctrl;
            out_valid_q <= 1'b1;
            if (dec_trap) state_q <= StTrap;
            if (dec_count && ill_cnt_q != '1) ill_cnt_q <= ill_cnt_q + ILL_CNT_W'(1);
        end else if (drain) begin
            out_valid_q <= 1'b0;
        end
    end

    assign ctrl     = ctrl_q;
    assign illCount = ill_cnt_q;

endmodule
